// File: rtl/display_frame_arbiter.sv
// Round-robin arbiter that picks one requester's digit frame and hands it to the
// display shift-register controller, re-sending blinking frames on every blink phase change.
module display_frame_arbiter #(
  parameter int          NUM_DIGITS   = 6,
  parameter int          NUM_REQ      = 3,
  parameter int          BLINK_CYCLES = 500000,
  parameter logic [7:0]  BLANK_CODE   = 8'hFF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*NUM_DIGITS*8-1:0]   req_data,
  input  logic [NUM_REQ*NUM_DIGITS-1:0]     req_blink,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                grant,
  output logic                              disp_valid,
  input  logic                              disp_ready,
  output logic [NUM_DIGITS*8-1:0]           dig_data_out
);

  localparam int FW = NUM_DIGITS * 8;
  localparam int CW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]            state;
  logic [FW-1:0]         buf_data;
  logic [NUM_DIGITS-1:0] buf_mask;
  logic [CW-1:0]         blink_cnt;
  logic                  blink_phase;
  logic                  pending;
  logic [PW-1:0]         rr_ptr;

  logic                  sel_found;
  logic [PW-1:0]         sel_idx;
  logic [NUM_REQ-1:0]    sel_onehot;
  logic [FW-1:0]         sel_data;
  logic [NUM_DIGITS-1:0] sel_mask;
  logic                  accept;
  logic                  toggle;
  logic                  next_phase;
  logic                  resend;

  function automatic logic [FW-1:0] blank_frame(input logic [FW-1:0] d,
                                                input logic [NUM_DIGITS-1:0] m,
                                                input logic ph);
    logic [FW-1:0] r;
    r = d;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (ph && m[i]) r[i*8 +: 8] = BLANK_CODE;
    end
    return r;
  endfunction

  // Two passes give "first valid at or after rr_ptr, wrapping" with constant indices only.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && req_valid[i] && (PW'(i) >= rr_ptr)) begin
        sel_found = 1'b1;
        sel_idx   = PW'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && req_valid[i]) begin
        sel_found = 1'b1;
        sel_idx   = PW'(i);
      end
    end
  end

  always_comb begin
    sel_onehot = '0;
    sel_data   = '0;
    sel_mask   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == PW'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_data      = req_data[i*FW +: FW];
        sel_mask      = req_blink[i*NUM_DIGITS +: NUM_DIGITS];
      end
    end
  end

  assign accept     = (state == S_IDLE) && sel_found;
  assign req_ready  = accept ? sel_onehot : '0;
  assign disp_valid = (state == S_SEND);
  assign toggle     = (blink_cnt == CW'(BLINK_CYCLES - 1));
  assign next_phase = blink_phase ^ toggle;
  assign resend     = (state == S_IDLE) && !sel_found && (|buf_mask) && (toggle || pending);

  // The output frame is built with the phase that will be current during SEND, then held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      buf_data     <= '0;
      buf_mask     <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      pending      <= 1'b0;
      rr_ptr       <= '0;
      grant        <= '0;
      dig_data_out <= {NUM_DIGITS{BLANK_CODE}};
    end else begin
      blink_cnt   <= toggle ? '0 : blink_cnt + CW'(1);
      blink_phase <= next_phase;
      case (state)
        S_IDLE: begin
          if (accept) begin
            buf_data     <= sel_data;
            buf_mask     <= sel_mask;
            dig_data_out <= blank_frame(sel_data, sel_mask, next_phase);
            grant        <= sel_onehot;
            rr_ptr       <= (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + PW'(1);
            pending      <= 1'b0;
            state        <= S_SEND;
          end else if (resend) begin
            dig_data_out <= blank_frame(buf_data, buf_mask, next_phase);
            pending      <= 1'b0;
            state        <= S_SEND;
          end
        end
        default: begin
          if (toggle) pending <= 1'b1;
          if (disp_ready) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_frame_arbiter.sv
// Bench for display_frame_arbiter: directed vector table, corner-case sequences and
// randomized traffic checked against a cycle-count based reference model.
module tb_display_frame_arbiter;

  localparam int ND = 6;
  localparam int NR = 3;
  localparam int B  = 8;

  logic           clk;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*ND*8-1:0] req_data;
  logic [NR*ND-1:0]   req_blink;
  logic [NR-1:0]  req_ready;
  logic [NR-1:0]  grant;
  logic           disp_valid;
  logic           disp_ready;
  logic [ND*8-1:0] dig_data_out;

  display_frame_arbiter #(
    .NUM_DIGITS(ND),
    .NUM_REQ(NR),
    .BLINK_CYCLES(B),
    .BLANK_CODE(8'hFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_blink(req_blink),
    .req_ready(req_ready),
    .grant(grant),
    .disp_valid(disp_valid),
    .disp_ready(disp_ready),
    .dig_data_out(dig_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: blink phase derived from cycles elapsed since reset.
  int          m_cyc;
  bit          m_send;
  int          m_grant;
  int          m_rr;
  bit          m_pend;
  logic [47:0] m_buf;
  logic [5:0]  m_mask;
  logic [47:0] m_out;

  logic [2:0]  s_ready;
  logic [2:0]  s_grant;
  logic        s_dv;
  logic [47:0] s_out;

  typedef struct {
    logic [2:0] v;
    bit         rdy;
    logic [2:0] e_ready;
    logic [2:0] e_grant;
    bit         e_dv;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit phase_of(input int c);
    return ((c / B) % 2) == 1;
  endfunction

  function automatic logic [47:0] blank(input logic [47:0] d, input logic [5:0] m, input bit ph);
    logic [47:0] r;
    r = d;
    for (int i = 0; i < ND; i++) if (ph && m[i]) r[i*8 +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic int find_winner(input logic [2:0] v);
    int w;
    w = -1;
    if (!m_send)
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_rr + k) % NR;
        if (v[j] && w < 0) w = j;
      end
    return w;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_send = 0; m_grant = -1; m_rr = 0; m_pend = 0;
    m_buf = '0; m_mask = '0; m_out = '1;
  endtask

  task automatic model_step(input logic [2:0] v, input bit rdy);
    int w;
    bit tog, nph;
    w   = find_winner(v);
    tog = (m_cyc % B) == B - 1;
    nph = phase_of(m_cyc + 1);
    if (!m_send) begin
      if (w >= 0) begin
        m_buf   = req_data[w*48 +: 48];
        m_mask  = req_blink[w*6 +: 6];
        m_out   = blank(m_buf, m_mask, nph);
        m_grant = w;
        m_rr    = (w + 1) % NR;
        m_pend  = 0;
        m_send  = 1;
      end else if (m_mask != 0 && (tog || m_pend)) begin
        m_out  = blank(m_buf, m_mask, nph);
        m_pend = 0;
        m_send = 1;
      end
    end else begin
      if (tog) m_pend = 1;
      if (rdy) m_send = 0;
    end
    m_cyc++;
  endtask

  // Called at a falling edge: drive, check, advance the model, wait for the next falling edge.
  task automatic step(input logic [2:0] v, input bit rdy);
    int w;
    logic [2:0] er, eg;
    req_valid  = v;
    disp_ready = rdy;
    #1;
    w  = find_winner(v);
    er = (w >= 0) ? 3'(1 << w) : 3'b000;
    eg = (m_grant >= 0) ? 3'(1 << m_grant) : 3'b000;
    s_ready = req_ready; s_grant = grant; s_dv = disp_valid; s_out = dig_data_out;
    chk("req_ready", 64'(s_ready), 64'(er));
    chk("grant", 64'(s_grant), 64'(eg));
    chk("disp_valid", 64'(s_dv), 64'(m_send));
    chk("dig_data_out", 64'(s_out), 64'(m_out));
    model_step(v, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int nsends;
    logic [7:0] exp_d0;
    logic [47:0] held;

    tbl[0] = '{3'b111, 1'b1, 3'b001, 3'b000, 1'b0};
    tbl[1] = '{3'b111, 1'b1, 3'b000, 3'b001, 1'b1};
    tbl[2] = '{3'b111, 1'b1, 3'b010, 3'b001, 1'b0};
    tbl[3] = '{3'b111, 1'b1, 3'b000, 3'b010, 1'b1};
    tbl[4] = '{3'b111, 1'b1, 3'b100, 3'b010, 1'b0};
    tbl[5] = '{3'b111, 1'b1, 3'b000, 3'b100, 1'b1};
    tbl[6] = '{3'b111, 1'b1, 3'b001, 3'b100, 1'b0};
    tbl[7] = '{3'b111, 1'b1, 3'b000, 3'b001, 1'b1};

    rst = 1'b1; req_valid = '0; disp_ready = 1'b0; req_data = '0; req_blink = '0;
    model_reset();
    @(negedge clk);
    #1;
    chk("reset_disp_valid", 64'(disp_valid), 64'(0));
    chk("reset_grant", 64'(grant), 64'(0));
    chk("reset_dig_data", 64'(dig_data_out), 64'(48'hFFFF_FFFF_FFFF));
    @(negedge clk);
    rst = 1'b0;

    // Round-robin with everyone requesting.
    req_data = {48'h665544332211, 48'hAABBCCDDEEFF, 48'h123456789ABC};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].rdy);
      chk("tbl_ready", 64'(s_ready), 64'(tbl[i].e_ready));
      chk("tbl_grant", 64'(s_grant), 64'(tbl[i].e_grant));
      chk("tbl_dv", 64'(s_dv), 64'(tbl[i].e_dv));
    end

    // Controller stalls for 20 cycles while the requester keeps asking.
    do_reset();
    req_data[47:0] = 48'h41_49_99_0D_25_9F;
    step(3'b001, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(3'b001, 1'b0);
      chk("stall_dv", 64'(s_dv), 64'(1));
      chk("stall_data", 64'(s_out), 64'(48'h41_49_99_0D_25_9F));
      chk("stall_ready", 64'(s_ready), 64'(0));
    end
    step(3'b000, 1'b1);
    step(3'b000, 1'b1);
    chk("stall_release_idle", 64'(s_dv), 64'(0));

    // Blink re-send with no other traffic.
    do_reset();
    req_data[47:0] = 48'h63_C1_11_09_01_1F;
    req_blink = '0;
    req_blink[5:0] = 6'b000001;
    step(3'b001, 1'b1);
    nsends = 0;
    exp_d0 = 8'h1F;
    for (int k = 1; k <= 40; k++) begin
      step(3'b000, 1'b1);
      chk("blink_grant", 64'(s_grant), 64'(3'b001));
      if (s_dv) begin
        nsends++;
        chk("blink_digit0", 64'(s_out[7:0]), 64'(exp_d0));
        chk("blink_upper", 64'(s_out[47:8]), 64'(40'h63_C1_11_09_01));
        exp_d0 = (exp_d0 == 8'h1F) ? 8'hFF : 8'h1F;
      end
    end
    chk("blink_send_count", 64'(nsends), 64'(6));

    // Blink toggle while stalled: output frozen, one re-send after the transfer.
    do_reset();
    step(3'b001, 1'b0);
    held = 48'h63_C1_11_09_01_1F;
    for (int k = 1; k <= 12; k++) begin
      step(3'b000, 1'b0);
      chk("frozen_data", 64'(s_out), 64'(held));
    end
    step(3'b000, 1'b1);
    step(3'b000, 1'b1);
    chk("pending_idle", 64'(s_dv), 64'(0));
    step(3'b000, 1'b1);
    chk("pending_resend_dv", 64'(s_dv), 64'(1));
    chk("pending_resend_d0", 64'(s_out[7:0]), 64'(8'hFF));

    // Asynchronous reset in the middle of SEND.
    do_reset();
    req_blink = '0;
    step(3'b001, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dv", 64'(disp_valid), 64'(0));
    chk("async_rst_grant", 64'(grant), 64'(0));
    chk("async_rst_data", 64'(dig_data_out), 64'(48'hFFFF_FFFF_FFFF));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(3'b000, 1'b1);
    chk("post_rst_no_frame", 64'(s_dv), 64'(0));
    step(3'b100, 1'b1);
    chk("post_rst_ready", 64'(s_ready), 64'(3'b100));
    step(3'b000, 1'b1);
    chk("post_rst_grant", 64'(s_grant), 64'(3'b100));

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [2:0] v;
      for (int r = 0; r < NR; r++) begin
        req_data[r*48 +: 48] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        req_blink[r*6 +: 6]  = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'b0;
        v[r] = ($urandom_range(0, 9) < 3);
      end
      step(v, $urandom_range(0, 9) < 7);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_frame_arbiter.md
DISPLAY_FRAME_ARBITER -- requirements
Module: display_frame_arbiter

Interface
REQ-001 Parameter NUM_DIGITS, default 6: digits per frame, 8 bits each.
REQ-002 Parameter NUM_REQ, default 3: frame requesters (timer, stopwatch, setup UI).
REQ-003 Parameter BLINK_CYCLES, default 500000: clk cycles per blink phase, >=2.
REQ-004 Parameter BLANK_CODE, default 8'hFF: segment byte substituted for a blanked digit.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 req_valid  in  NUM_REQ  requester i offers a frame.
REQ-008 req_data  in  NUM_REQ x NUM_DIGITS x 8  frame per requester, digit 0 in LSB byte.
REQ-009 req_blink  in  NUM_REQ x NUM_DIGITS  per-requester blink mask, sampled with req_data.
REQ-010 req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
REQ-011 grant  out  NUM_REQ  one-hot owner of the displayed frame; 0 until first accept.
REQ-012 disp_valid  out  1  frame on dig_data_out offered to the shift-register controller.
REQ-013 disp_ready  in  1  controller accepts frame (transfer = disp_valid & disp_ready).
REQ-014 dig_data_out  out  NUM_DIGITS x 8  frame to dig_data_in of the controller.

Function
REQ-015 States: IDLE, SEND; SHALL be a two-state FSM plus frame buffer, blink counter, round-robin pointer.
REQ-016 IDLE: if any req_valid, grant SHALL go to the first set requester at or after rr_ptr (wrapping), in that same cycle req_ready[i]=1, req_data[i]/req_blink[i] latched into buffer, grant<=onehot(i), rr_ptr<=(i+1) mod NUM_REQ, next state SEND.
REQ-017 req_ready SHALL be asserted only in IDLE and for exactly one requester per cycle; a requester dropping req_valid before accept SHALL NOT be granted.
REQ-018 SEND: disp_valid=1, dig_data_out stable; on transfer cycle next state IDLE; transfer latency from accept to first disp_valid is 1 cycle.
REQ-019 dig_data_out digit d SHALL equal BLANK_CODE when blink_phase=1 and buffered mask[d]=1, else buffered byte d; the value presented in SEND SHALL be frozen at SEND entry.
REQ-020 Blink counter SHALL count 0..BLINK_CYCLES-1 and wrap, toggling blink_phase on wrap, free-running regardless of state.
REQ-021 On blink_phase toggle with a buffered frame having any mask bit set and no requester valid, the FSM SHALL re-enter SEND with the buffered frame (re-send) without pulsing req_ready.
REQ-022 A toggle occurring while in SEND SHALL set a pending flag; re-send SHALL occur on the next IDLE cycle with no req_valid; a new accept clears the flag.
REQ-023 New requests SHALL take precedence over re-send in IDLE.
REQ-024 disp_ready held high SHALL yield one transfer per frame; back-to-back accepts SHALL be spaced by at least 2 cycles (accept, SEND, IDLE).
REQ-025 disp_ready high while disp_valid low SHALL have no effect.

Reset
REQ-026 While rst=1: state IDLE, req_ready=0, grant=0, disp_valid=0, dig_data_out all BLANK_CODE, buffer mask 0, rr_ptr=0, blink counter 0, blink_phase 0, pending 0.
REQ-027 rst asserted during SEND SHALL drop disp_valid asynchronously; no frame SHALL be presented after release until a new accept.

Verification
REQ-028 After reset, req_valid=3'b111 held, disp_ready=1 -> grants in order 001,010,100,001, each req_ready one cycle, disp_valid one cycle after each accept.
REQ-029 req_valid=001, req_data[0]=48'h41_49_99_0D_25_9F, disp_ready=0 for 20 cycles -> disp_valid high and dig_data_out stable for 20 cycles, no further req_ready; disp_ready=1 -> return to IDLE next cycle.
REQ-030 BLINK_CYCLES=8, mask 6'b000001 on frame 48'h63_C1_11_09_01_1F, no further requests -> re-send every 8 cycles alternating digit0 = 8'h1F / 8'hFF, grant unchanged, req_ready stays 0.
REQ-031 Blink toggle while disp_ready=0 holds SEND -> no change to dig_data_out during SEND; one re-send follows the transfer.
REQ-032 rst pulsed mid-SEND -> disp_valid=0 immediately, dig_data_out all 8'hFF, grant=0; next req_valid=100 granted to requester 2 first.
